edge_detect_multi: RTL

Parametrised, multi-channel successor to the single-bit Mealy edge detector. Each of `WIDTH` independent channels synchronises its asynchronous input, rejects glitches shorter than `FILTER_LEN` clocks and tracks a filtered level. On each filtered rising, falling or either edge, per the channel's mode, it emits a one-cycle registered pulse. It also keeps a sticky flag and a saturating event counter per channel. It sits between raw external inputs (buttons, strobes, interrupt lines) and control FSMs that need clean single-cycle events.

---
 rtl/edge_detect_multi_if.sv | 22 ++
 rtl/edge_detect_multi.sv | 120 ++++++++++++
 2 files changed

// File: rtl/edge_detect_multi_if.sv
// edge_detect_multi_if: channel inputs, mode/clear controls and event outputs of edge_detect_multi
//   in_i     raw asynchronous channel inputs, WIDTH bits
//   in_mode  per-channel report mode, 2 bits per channel (00 off, 01 rise, 10 fall, 11 both)
//   in_clr   synchronous clear of sticky flags and counters
//   o_q      one-cycle event pulse per channel
//   o_level  filtered level per channel
//   o_sticky per-channel event seen since last clear
//   o_cnt    per-channel saturating event count, CNT_W bits per channel
interface edge_detect_multi_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]       in_i;
    logic [2*WIDTH-1:0]     in_mode;
    logic                   in_clr;
    logic [WIDTH-1:0]       o_q;
    logic [WIDTH-1:0]       o_level;
    logic [WIDTH-1:0]       o_sticky;
    logic [WIDTH*CNT_W-1:0] o_cnt;
    modport master (output in_i, in_mode, in_clr, input o_q, o_level, o_sticky, o_cnt);
    modport slave (input in_i, in_mode, in_clr, output o_q, o_level, o_sticky, o_cnt);
endinterface

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel synchroniser, glitch filter, gated edge pulse, sticky flag and saturating counter
//   in_clk   clock, all state on rising edge
//   in_rst_n asynchronous active-low reset
//   bus      edge_detect_multi_if slave: in_i, in_mode, in_clr in; o_q, o_level, o_sticky, o_cnt out
module edge_detect_multi #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_W       = 8
) (
    input logic            in_clk,
    input logic            in_rst_n,
    edge_detect_multi_if.slave bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    typedef enum logic [1:0] {LOW, CHK_HIGH, HIGH, CHK_LOW} state_t;
    logic [WIDTH-1:0]       q_v;
    logic [WIDTH-1:0]       lvl_v;
    logic [WIDTH-1:0]       stk_v;
    logic [WIDTH*CNT_W-1:0] cnt_v;
    genvar c;
    generate
        for (c = 0; c < WIDTH; c = c + 1) begin : g_ch
            logic             s;
            state_t           st, st_n;
            logic [FW-1:0]    f, f_n;
            logic             done, rise, fall, ev;
            logic [1:0]       mode;
            logic             q, lvl, stk;
            logic [CNT_W-1:0] cnt;
            if (SYNC_STAGES == 0) begin : g_bypass
                assign s = bus.in_i[c];
            end else begin : g_sync
                logic [SYNC_STAGES-1:0] sy;
                always_ff @(posedge in_clk or negedge in_rst_n)
                    if (!in_rst_n) sy <= '0;
                    else begin
                        sy[0] <= bus.in_i[c];
                        for (int k = 1; k < SYNC_STAGES; k++) sy[k] <= sy[k-1];
                    end
                assign s = sy[SYNC_STAGES-1];
            end
            // the sample seen this cycle is the FILTER_LEN-th consecutive one
            assign done = (32'(f) + 1 >= FILTER_LEN);
            always_ff @(posedge in_clk or negedge in_rst_n)
                if (!in_rst_n) begin
                    st <= LOW;
                    f  <= '0;
                end else begin
                    st <= st_n;
                    f  <= f_n;
                end
            always_comb begin
                st_n = st;
                f_n  = f;
                rise = 1'b0;
                fall = 1'b0;
                case (st)
                    LOW:
                        if (s) begin
                            if (FILTER_LEN == 1) begin
                                st_n = HIGH;
                                rise = 1'b1;
                            end else begin
                                st_n = CHK_HIGH;
                                f_n  = FW'(1);
                            end
                        end
                    CHK_HIGH:
                        if (!s) st_n = LOW;
                        else if (done) begin
                            st_n = HIGH;
                            rise = 1'b1;
                        end else f_n = f + FW'(1);
                    HIGH:
                        if (!s) begin
                            if (FILTER_LEN == 1) begin
                                st_n = LOW;
                                fall = 1'b1;
                            end else begin
                                st_n = CHK_LOW;
                                f_n  = FW'(1);
                            end
                        end
                    CHK_LOW:
                        if (s) st_n = HIGH;
                        else if (done) begin
                            st_n = LOW;
                            fall = 1'b1;
                        end else f_n = f + FW'(1);
                    default: st_n = LOW;
                endcase
            end
            assign mode = bus.in_mode[2*c +: 2];
            assign ev   = (rise & mode[0]) | (fall & mode[1]);
            // an event on the same edge as a clear restarts the count at one
            always_ff @(posedge in_clk or negedge in_rst_n)
                if (!in_rst_n) begin
                    q   <= 1'b0;
                    lvl <= 1'b0;
                    stk <= 1'b0;
                    cnt <= '0;
                end else begin
                    q   <= ev;
                    lvl <= (st_n == HIGH) || (st_n == CHK_LOW);
                    stk <= ev | (stk & ~bus.in_clr);
                    cnt <= ev ? (bus.in_clr ? CNT_W'(1) : (&cnt ? cnt : cnt + CNT_W'(1)))
                              : (bus.in_clr ? '0 : cnt);
                end
            assign q_v[c]                = q;
            assign lvl_v[c]              = lvl;
            assign stk_v[c]              = stk;
            assign cnt_v[c*CNT_W +: CNT_W] = cnt;
        end
    endgenerate
    assign bus.o_q      = q_v;
    assign bus.o_level  = lvl_v;
    assign bus.o_sticky = stk_v;
    assign bus.o_cnt    = cnt_v;
endmodule
